rob_completion_arbiter: RTL and testbench
=========================================

// Module: rob_completion_arbiter
// PURPOSE
//   Shares the reorder buffer's single completion port among NUM_REQ functional units.
//   - Each unit hands over the ROB tag of a finished instruction.
//   - Tags are held in a one-entry buffer per unit.
//   - One buffered tag per cycle is granted round-robin onto complete_instr/completed_addr.
//   - Sits between the execute-stage writeback logic and the ROB completion inputs.
// PARAMETERS
//   NUM_REQ         4  number of requesting functional units (legal range 2..8)
//   ROB_ADDR_WIDTH  3  ROB tag width; must match the ROB instance
// PORTS
//   clock           in   1                         system clock, rising edge
//   reset           in   1                         asynchronous, active-high
//   flush           in   1                         synchronous; discard all buffered completions
//   req_valid       in   NUM_REQ                   unit i presents a completion
//   req_tag         in   NUM_REQ*ROB_ADDR_WIDTH    unit i tag at [i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]
//   req_ready       out  NUM_REQ                   unit i's completion is accepted this cycle
//   complete_instr  out  1                         to ROB complete_instr
//   completed_addr  out  ROB_ADDR_WIDTH            to ROB completed_addr
//   grant           out  NUM_REQ                   one-hot; which buffer is driving the port
// BEHAVIOUR
//   State
//   - pend_valid[i], pend_tag[i]: one-entry buffer per unit.
//   - rr_ptr: $clog2(NUM_REQ) bits, the highest-priority index.
//   Reset (asynchronous)
//   - pend_valid = 0, pend_tag = 0, rr_ptr = 0.
//   - All outputs are 0 while reset is high, including req_ready.
//   Handshake
//   - req_ready[i] = !reset && !flush && (!pend_valid[i] || grant[i]).
//   - A transfer occurs at a rising edge where req_valid[i] && req_ready[i].
//   - On a transfer: pend_valid[i] <= 1 and pend_tag[i] <= that unit's tag.
//   - Units must hold req_valid and req_tag stable until the transfer occurs.
//   Arbitration (combinational from state)
//   - Scan indices rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
//   - grant = one-hot of the first i with pend_valid[i]; grant = 0 if none.
//   - complete_instr = |grant.
//   - completed_addr = pend_tag of the granted index; 0 when no grant.
//   - At the edge ending a cycle with a grant to k:
//     - pend_valid[k] <= 0, unless a new transfer from k loads the buffer in the same edge (load wins).
//     - rr_ptr <= (k+1) mod NUM_REQ.
//     - For non-power-of-2 NUM_REQ, the wrap goes from NUM_REQ-1 to 0.
//   - No grant -> rr_ptr unchanged.
//   Latency and throughput
//   - A tag accepted at edge E is presented to the ROB in the cycle after E.
//   - The ROB captures it at edge E+1, so minimum latency is 1 cycle.
//   - A lone active unit sustains 1 completion/cycle.
//   - N contending units are each served within N cycles; no starvation.
//   Flush
//   - When flush=1 at an edge: all pend_valid <= 0; rr_ptr is unchanged; no new transfers are taken.
//   - grant and complete_instr still reflect the buffered state during the flush cycle.
//   - The ROB may therefore see one completion in that cycle; the ROB flush owner handles it.
//   Reset mid-operation
//   - Buffered tags are lost.
//   - complete_instr drops to 0 immediately, without waiting for a clock edge.
//   Simultaneous events
//   - Duplicate tags from different units are not checked.
//   - Each is forwarded in arbitration order.
// TESTING
//   1. Single: unit0 valid with tag 5 for one cycle -> next cycle complete_instr=1, addr=5, grant=0001; the following cycle complete_instr=0.
//   2. Contention: units 0..3 valid in the same cycle with tags 1,2,3,4, rr_ptr=0 -> addr 1,2,3,4 on 4 consecutive cycles; rr_ptr ends at 0.
//   3. Fairness: units 0 and 2 valid every cycle -> grants alternate 0001,0100,0001,...; both req_ready toggle accordingly.
//   4. Streaming: unit1 sends tags 0..7 back-to-back -> req_ready[1] stays 1; addr 0..7 on 8 consecutive cycles.
//   5. Flush: 3 units buffered, flush=1 for one cycle while unit3 is valid -> req_ready=0 that cycle; afterwards pend_valid=0, complete_instr=0, and unit3 is accepted after flush drops.
//   6. Reset: assert reset between clock edges with 2 entries buffered -> complete_instr, grant and req_ready go 0 at once; after release, the first completion comes from new input only.

Source files
------------

// File: rtl/rob_completion_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : rob_completion_arbiter_if
//  Purpose  : Bundle of completion request/grant signals between the execute
//             stage functional units and the ROB completion arbiter.
//  Signals  : req_valid      unit i presents a completion
//             req_tag        unit i tag at [i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]
//             req_ready      unit i's completion is accepted this cycle
//             complete_instr completion strobe towards the ROB
//             completed_addr ROB tag being completed
//             grant          one-hot, which unit buffer drives the port
//  Modports : master - functional-unit / ROB side
//             slave  - arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface rob_completion_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int ROB_ADDR_WIDTH = 3
);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*ROB_ADDR_WIDTH-1:0] req_tag;
  logic [NUM_REQ-1:0]                req_ready;
  logic                              complete_instr;
  logic [ROB_ADDR_WIDTH-1:0]         completed_addr;
  logic [NUM_REQ-1:0]                grant;

  modport master (
    output req_valid,
    output req_tag,
    input  req_ready,
    input  complete_instr,
    input  completed_addr,
    input  grant
  );

  modport slave (
    input  req_valid,
    input  req_tag,
    output req_ready,
    output complete_instr,
    output completed_addr,
    output grant
  );

endinterface
`default_nettype wire

// File: rtl/rob_completion_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rob_completion_arbiter
//  Purpose  : Shares the ROB's single completion port among NUM_REQ functional
//             units. Each unit hands over a finished instruction's ROB tag
//             into a one-entry buffer; one buffered tag per cycle is granted
//             round-robin onto complete_instr/completed_addr.
//  Ports    : clock - system clock, rising edge
//             reset - asynchronous, active-high
//             flush - synchronous, discards all buffered completions
//             bus   - request/grant bundle (slave modport)
//  Revision : 1.0 - initial release
// ============================================================================
module rob_completion_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ROB_ADDR_WIDTH = 3
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  input  wire logic                 flush,
  rob_completion_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Per-unit one-entry buffers and the round-robin priority pointer
  logic [NUM_REQ-1:0]        pend_valid_q, pend_valid_d;
  logic [ROB_ADDR_WIDTH-1:0] pend_tag_q [NUM_REQ];
  logic [ROB_ADDR_WIDTH-1:0] pend_tag_d [NUM_REQ];
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]        grant;
  logic                      grant_any;
  logic [PTR_W-1:0]          grant_idx;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        xfer;
  logic [ROB_ADDR_WIDTH-1:0] in_tag [NUM_REQ];

  logic [SUM_W-1:0]          scan_sum;
  logic [PTR_W-1:0]          scan_idx;

  // Arbitration: first pending buffer at or after rr_ptr, wrapping at NUM_REQ.
  // The sum is one bit wider than the pointer so non-power-of-2 wrap is exact.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_sum = {1'b0, rr_ptr_q} + SUM_W'(off);
      if (scan_sum >= SUM_W'(NUM_REQ)) begin
        scan_sum = scan_sum - SUM_W'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!grant_any && pend_valid_q[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // A unit may hand over when its buffer is empty or is being drained this
  // cycle, which lets a lone unit stream one completion per cycle.
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unit
      assign req_ready[i] = !reset && !flush && (!pend_valid_q[i] || grant[i]);
      assign xfer[i]      = bus.req_valid[i] && req_ready[i];
      assign in_tag[i]    = bus.req_tag[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH];
    end
  endgenerate

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_tag_d   = pend_tag_q;
    rr_ptr_d     = rr_ptr_q;
    if (flush) begin
      // The pointer is deliberately left alone; only the buffers are dropped
      pend_valid_d = '0;
    end else begin
      pend_valid_d = pend_valid_q & ~grant;
      // A load in the same edge as the drain wins, so streaming never bubbles
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer[i]) begin
          pend_valid_d[i] = 1'b1;
          pend_tag_d[i]   = in_tag[i];
        end
      end
      if (grant_any) begin
        rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_valid_q <= '0;
      rr_ptr_q     <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_tag_q[i] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        pend_tag_q[i] <= pend_tag_d[i];
      end
    end
  end

  // Outputs derive from state cleared asynchronously, so they fall at once
  // when reset rises.
  assign bus.req_ready      = req_ready;
  assign bus.grant          = grant;
  assign bus.complete_instr = grant_any;
  assign bus.completed_addr = grant_any ? pend_tag_q[grant_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_rob_completion_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_completion_arbiter
//  Purpose  : Directed self-checking bench for rob_completion_arbiter
//             (NUM_REQ=4, ROB_ADDR_WIDTH=3). Inputs change and outputs are
//             sampled just after the falling clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rob_completion_arbiter;

  logic clock;
  logic reset;
  logic flush;
  int   n_vec;
  int   n_err;

  logic [7:0] obs;
  logic [7:0] exp_o;
  logic [3:0] exp_r;

  rob_completion_arbiter_if #(.NUM_REQ(4), .ROB_ADDR_WIDTH(3)) bus ();

  rob_completion_arbiter #(.NUM_REQ(4), .ROB_ADDR_WIDTH(3)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {complete_instr, grant, completed_addr}
  function automatic logic [7:0] port_state();
    return {bus.complete_instr, bus.grant, bus.completed_addr};
  endfunction

  task automatic test_reset();
    @(negedge clock); #1;
    n_vec++;
    if ({port_state(), bus.req_ready} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required %b", {port_state(), bus.req_ready}, 12'h000);
    end
    reset = 1'b0; #1;
    n_vec++;
    if (bus.req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b required %b", bus.req_ready, 4'b1111);
    end
  endtask

  task automatic test_contention();
    logic [7:0] tbl [4];
    tbl[0] = {1'b1, 4'b0001, 3'd1};
    tbl[1] = {1'b1, 4'b0010, 3'd2};
    tbl[2] = {1'b1, 4'b0100, 3'd3};
    tbl[3] = {1'b1, 4'b1000, 3'd4};
    @(negedge clock);
    bus.req_valid = 4'b1111;
    bus.req_tag   = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL contention_ready: got %b required %b", bus.req_ready, 4'b1111);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      bus.req_valid = 4'b0000;
      #1;
      obs = port_state();
      n_vec++;
      if (obs !== tbl[k]) begin
        n_err++;
        $display("FAIL contention_cycle%0d: got %b required %b", k, obs, tbl[k]);
      end
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL contention_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  task automatic test_single();
    @(negedge clock);
    bus.req_valid   = 4'b0001;
    bus.req_tag     = 12'h000;
    bus.req_tag[2:0] = 3'd5;
    #1;
    n_vec++;
    if (bus.req_ready[0] !== 1'b1) begin
      n_err++;
      $display("FAIL single_ready: got %b required %b", bus.req_ready[0], 1'b1);
    end
    @(negedge clock);
    bus.req_valid = 4'b0000;
    #1;
    obs = port_state();
    exp_o = {1'b1, 4'b0001, 3'd5};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL single_grant: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL single_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  // After test_single the pointer sits at 1, so unit 3 beats unit 0
  task automatic test_rr_pointer();
    @(negedge clock);
    bus.req_valid = 4'b1001;
    bus.req_tag   = {3'd6, 3'd0, 3'd0, 3'd2};
    @(negedge clock);
    bus.req_valid = 4'b0000;
    #1;
    obs = port_state();
    exp_o = {1'b1, 4'b1000, 3'd6};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL rr_first: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    exp_o = {1'b1, 4'b0001, 3'd2};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL rr_second: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL rr_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  // Pointer at 1 on entry: unit 2 is served first, then alternation
  task automatic test_fairness();
    @(negedge clock);
    bus.req_valid = 4'b0101;
    bus.req_tag   = {3'd0, 3'd7, 3'd0, 3'd6};
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL fair_ready_load: got %b required %b", bus.req_ready, 4'b1111);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      if (k == 5) bus.req_valid = 4'b0000;
      #1;
      obs = port_state();
      exp_o = (k % 2 == 0) ? {1'b1, 4'b0100, 3'd7} : {1'b1, 4'b0001, 3'd6};
      exp_r = (k % 2 == 0) ? 4'b1110 : 4'b1011;
      n_vec++;
      if (obs !== exp_o) begin
        n_err++;
        $display("FAIL fair_grant%0d: got %b required %b", k, obs, exp_o);
      end
      n_vec++;
      if (bus.req_ready !== exp_r) begin
        n_err++;
        $display("FAIL fair_ready%0d: got %b required %b", k, bus.req_ready, exp_r);
      end
    end
    @(negedge clock); #1;
    obs = port_state();
    exp_o = {1'b1, 4'b0100, 3'd7};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL fair_drain: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL fair_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] t;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k < 8) begin
        t = 3'(k);
        bus.req_valid    = 4'b0010;
        bus.req_tag[5:3] = t;
      end else begin
        bus.req_valid = 4'b0000;
      end
      #1;
      obs = port_state();
      if (k > 0 && k < 9) begin
        t = 3'(k - 1);
        exp_o = {1'b1, 4'b0010, t};
        n_vec++;
        if (obs !== exp_o) begin
          n_err++;
          $display("FAIL stream_out%0d: got %b required %b", k, obs, exp_o);
        end
      end
      if (k < 8) begin
        n_vec++;
        if (bus.req_ready[1] !== 1'b1) begin
          n_err++;
          $display("FAIL stream_ready%0d: got %b required %b", k, bus.req_ready[1], 1'b1);
        end
      end
      if (k == 9) begin
        n_vec++;
        if (obs !== 8'h00) begin
          n_err++;
          $display("FAIL stream_idle: got %b required %b", obs, 8'h00);
        end
      end
    end
  endtask

  // Pointer at 2 on entry
  task automatic test_flush();
    @(negedge clock);
    bus.req_valid = 4'b0111;
    bus.req_tag   = {3'd0, 3'd3, 3'd2, 3'd1};
    @(negedge clock);
    bus.req_valid = 4'b1000;
    bus.req_tag   = {3'd5, 3'd0, 3'd0, 3'd0};
    flush = 1'b1;
    #1;
    n_vec++;
    if (bus.req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL flush_ready: got %b required %b", bus.req_ready, 4'b0000);
    end
    obs = port_state();
    exp_o = {1'b1, 4'b0100, 3'd3};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL flush_cycle_grant: got %b required %b", obs, exp_o);
    end
    @(negedge clock);
    flush = 1'b0;
    #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL flush_cleared: got %b required %b", obs, 8'h00);
    end
    n_vec++;
    if (bus.req_ready !== 4'b1111) begin
      n_err++;
      $display("FAIL flush_after_ready: got %b required %b", bus.req_ready, 4'b1111);
    end
    @(negedge clock);
    bus.req_valid = 4'b0000;
    #1;
    obs = port_state();
    exp_o = {1'b1, 4'b1000, 3'd5};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL flush_unit3: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL flush_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  // Pointer at 0 on entry
  task automatic test_midreset();
    @(negedge clock);
    bus.req_valid = 4'b0110;
    bus.req_tag   = {3'd0, 3'd7, 3'd6, 3'd0};
    @(negedge clock);
    bus.req_valid = 4'b0000;
    #1;
    obs = port_state();
    exp_o = {1'b1, 4'b0010, 3'd6};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL midreset_before: got %b required %b", obs, exp_o);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({port_state(), bus.req_ready} !== 12'h000) begin
      n_err++;
      $display("FAIL midreset_async: got %b required %b", {port_state(), bus.req_ready}, 12'h000);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_lost: got %b required %b", obs, 8'h00);
    end
    bus.req_valid = 4'b1000;
    bus.req_tag   = {3'd2, 3'd0, 3'd0, 3'd0};
    @(negedge clock);
    bus.req_valid = 4'b0000;
    #1;
    obs = port_state();
    exp_o = {1'b1, 4'b1000, 3'd2};
    n_vec++;
    if (obs !== exp_o) begin
      n_err++;
      $display("FAIL midreset_new: got %b required %b", obs, exp_o);
    end
    @(negedge clock); #1;
    obs = port_state();
    n_vec++;
    if (obs !== 8'h00) begin
      n_err++;
      $display("FAIL midreset_idle: got %b required %b", obs, 8'h00);
    end
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    reset         = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_tag   = 12'h000;
    test_reset();
    test_contention();
    test_single();
    test_rr_pointer();
    test_fairness();
    test_back_to_back();
    test_flush();
    test_midreset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
